// File: rtl/uart_mem_bridge_pkg.sv
// Shared constants and state type for the UART-to-memory command bridge.
package uart_mem_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        MEM,
        RESP
    } state_e;

endpackage

// File: rtl/uart_mem_bridge.sv
// Byte-serial command parser turning UART 'W'/'R' frames into 32-bit memory transactions.
// Optional inter-byte timeout on partial commands: define UART_BRIDGE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a command byte
// ADDR  | collecting address bytes A0..A3
// DATA  | collecting write data bytes D0..D3
// MEM   | memory request held until memReady
// RESP  | pushing response bytes to the UART transmit FIFO
module uart_mem_bridge
    import uart_mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  uByte,
    input  logic        uCanRead,
    output logic        uRead,
    output logic [7:0]  uWByte,
    output logic        uWrite,
    input  logic        uCanWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] memRData,
    input  logic        memReady
);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] resp_buf_q, resp_buf_d;
    logic [2:0]  resp_cnt_q, resp_cnt_d;
    logic        consume;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    // Reset gates the handshakes so nothing is popped or pushed while it is held.
    assign consume  = uCanRead && !reset &&
                      (state_q == IDLE || state_q == ADDR || state_q == DATA);
    assign uRead    = consume;
    assign uWrite   = (state_q == RESP) && uCanWrite && !reset;
    assign uWByte   = resp_buf_q[7:0];
    assign memAddr  = addr_q;
    assign memWData = wdata_q;
    assign memRead  = rd_q;
    assign memWrite = wr_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        resp_buf_d = resp_buf_q;
        resp_cnt_d = resp_cnt_q;
`ifdef UART_BRIDGE_TIMEOUT_EN
        tmr_d      = tmr_q;
`endif
        case (state_q)
            IDLE: begin
                if (consume) begin
                    if (uByte == CMD_WRITE || uByte == CMD_READ) begin
                        cmd_d   = uByte;
                        idx_d   = 2'd0;
                        state_d = ADDR;
`ifdef UART_BRIDGE_TIMEOUT_EN
                        tmr_d   = TMR_LOAD;
`endif
                    end else begin
                        resp_buf_d = {24'h0, RSP_ERR};
                        resp_cnt_d = 3'd1;
                        state_d    = RESP;
                    end
                end
            end
            ADDR, DATA: begin
                if (consume) begin
                    if (state_q == ADDR) addr_d[{idx_q, 3'b000} +: 8] = uByte;
                    else                 wdata_d[{idx_q, 3'b000} +: 8] = uByte;
                    idx_d = idx_q + 2'd1;
`ifdef UART_BRIDGE_TIMEOUT_EN
                    tmr_d = TMR_LOAD;
`endif
                    if (idx_q == 2'd3) begin
                        if (state_q == ADDR && cmd_q == CMD_WRITE) begin
                            state_d = DATA;
                        end else if (state_q == ADDR) begin
                            state_d = MEM;
                            rd_d    = 1'b1;
                        end else begin
                            state_d = MEM;
                            wr_d    = 1'b1;
                        end
                    end
                end
`ifdef UART_BRIDGE_TIMEOUT_EN
                // Terminal count: the partial command is dropped without a reply.
                else if (tmr_q <= TMR_W'(1)) state_d = IDLE;
                else tmr_d = tmr_q - TMR_W'(1);
`endif
            end
            MEM: begin
                if (memReady) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = RESP;
                    if (rd_q) begin
                        resp_buf_d = memRData;
                        resp_cnt_d = 3'd4;
                    end else begin
                        resp_buf_d = {24'h0, RSP_OK};
                        resp_cnt_d = 3'd1;
                    end
                end
            end
            RESP: begin
                if (uWrite) begin
                    resp_buf_d = {8'h0, resp_buf_q[31:8]};
                    resp_cnt_d = resp_cnt_q - 3'd1;
                    if (resp_cnt_q == 3'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            cmd_q      <= 8'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            resp_buf_q <= 32'h0;
            resp_cnt_q <= 3'd0;
`ifdef UART_BRIDGE_TIMEOUT_EN
            tmr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            resp_buf_q <= resp_buf_d;
            resp_cnt_q <= resp_cnt_d;
`ifdef UART_BRIDGE_TIMEOUT_EN
            tmr_q      <= tmr_d;
`endif
        end
    end

endmodule
